// File: rtl/turf_cmd_tx.sv
// Serial CMD-link transmitter: start bit, MSB-first payload, optional odd parity, idle gap.
// Optional feature: define CMD_TX_PARITY_EN to insert an odd-parity bit after the payload.
module turf_cmd_tx #(
    parameter int DATA_W   = 32,
    parameter int CLK_DIV  = 4,
    parameter int GAP_BITS = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] cmd_dat_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    output logic              busy_o,
    output logic              sent_o,
    output logic [15:0]       sent_cnt_o,
    output logic              CMD
);

    localparam int PW = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
    localparam int BW = (DATA_W   > 1) ? $clog2(DATA_W)   : 1;
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [PW-1:0] PRESC_RELOAD = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST     = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef CMD_TX_PARITY_EN
        S_PARITY,
`endif
        S_GAP
    } state_t;

    state_t            state;
    logic [PW-1:0]     presc;
    logic [BW-1:0]     bit_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [DATA_W-1:0] shreg;
    logic [15:0]       sent_cnt;
    logic              cmd_q;
    logic              sent_q;
    logic              bit_end;
    logic              accept;
`ifdef CMD_TX_PARITY_EN
    logic              par_q;
`endif

    assign cmd_ready_o = (state == S_IDLE);
    assign busy_o      = ~cmd_ready_o;
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign bit_end     = (presc == '0);
    assign sent_o      = sent_q;
    assign sent_cnt_o  = sent_cnt;
    assign CMD         = cmd_q;

    // Every bit-time is CLK_DIV cycles; the prescaler reloads at each boundary, so
    // CMD changes only on boundaries and always comes straight from cmd_q.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: the shift register is a plain flop bank, not a RAM, so clearing it
            // on reset is cheap and keeps the post-reset state fully deterministic.
            state    <= S_IDLE;
            presc    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            shreg    <= '0;
            sent_cnt <= '0;
            cmd_q    <= 1'b0;
            sent_q   <= 1'b0;
`ifdef CMD_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking throughout; every branch reads pre-edge state.
            sent_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_q <= 1'b0;
                    if (accept) begin
                        shreg <= cmd_dat_i;
`ifdef CMD_TX_PARITY_EN
                        par_q <= ~^cmd_dat_i;
`endif
                        presc <= PRESC_RELOAD;
                        cmd_q <= 1'b1;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        presc   <= PRESC_RELOAD;
                        cmd_q   <= shreg[DATA_W-1];
                        shreg   <= shreg << 1;
                        bit_cnt <= BIT_LAST;
                        state   <= S_DATA;
                    end else begin
                        presc <= presc - PW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        presc <= PRESC_RELOAD;
                        if (bit_cnt == '0) begin
`ifdef CMD_TX_PARITY_EN
                            cmd_q   <= par_q;
                            state   <= S_PARITY;
`else
                            cmd_q   <= 1'b0;
                            gap_cnt <= GAP_LAST;
                            state   <= S_GAP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt - BW'(1);
                            cmd_q   <= shreg[DATA_W-1];
                            shreg   <= shreg << 1;
                        end
                    end else begin
                        presc <= presc - PW'(1);
                    end
                end
`ifdef CMD_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        presc   <= PRESC_RELOAD;
                        cmd_q   <= 1'b0;
                        gap_cnt <= GAP_LAST;
                        state   <= S_GAP;
                    end else begin
                        presc <= presc - PW'(1);
                    end
                end
`endif
                S_GAP: begin
                    cmd_q <= 1'b0;
                    if (bit_end) begin
                        presc <= PRESC_RELOAD;
                        if (gap_cnt == '0) begin
                            sent_q   <= 1'b1;
                            sent_cnt <= sent_cnt + 16'd1;
                            state    <= S_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - GW'(1);
                        end
                    end else begin
                        presc <= presc - PW'(1);
                    end
                end
                default: begin
                    cmd_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turf_cmd_tx.sv
// Self-checking bench for turf_cmd_tx: table vectors, corner sequences and random frames
// on two instances (CLK_DIV=4 and CLK_DIV=1); follows the CMD_TX_PARITY_EN build setting.
module tb_turf_cmd_tx;

    localparam int P = `ifdef CMD_TX_PARITY_EN 1 `else 0 `endif ;
    localparam int FRAME_BITS = 1 + 8 + P + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [7:0]  dat0 = '0, dat1 = '0;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic        ready0, ready1, busy0, busy1, sent0, sent1, cmd0, cmd1;
    logic [15:0] cnt0, cnt1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt0 = '0, exp_cnt1 = '0;

    always #5 clk = ~clk;

    turf_cmd_tx #(.DATA_W(8), .CLK_DIV(4), .GAP_BITS(2)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .cmd_dat_i(dat0), .cmd_valid_i(valid0),
        .cmd_ready_o(ready0), .busy_o(busy0), .sent_o(sent0), .sent_cnt_o(cnt0), .CMD(cmd0)
    );

    turf_cmd_tx #(.DATA_W(8), .CLK_DIV(1), .GAP_BITS(2)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .cmd_dat_i(dat1), .cmd_valid_i(valid1),
        .cmd_ready_o(ready1), .busy_o(busy1), .sent_o(sent1), .sent_cnt_o(cnt1), .CMD(cmd1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: line level for bit-time idx of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b1;
        if (idx >= 1 && idx <= 8) return d[8 - idx];
        if (P == 1 && idx == 9) return ($countones(d) % 2) == 0;
        return 1'b0;
    endfunction

    // Called at a negedge in the cycle that becomes "cycle 0"; returns at the negedge of
    // cycle FRAME_BITS*div+1, which may itself serve as the next cycle 0.
    task automatic send(input bit sel, input logic [7:0] d, input logic exp_par, input bit hold);
        int div = sel ? 1 : 4;
        int fl  = FRAME_BITS * div;
        int idx;
        logic exp_bit;
        if (sel) begin dat1 = d; valid1 = 1'b1; end
        else     begin dat0 = d; valid0 = 1'b1; end
        check("ready_at_accept", sel ? ready1 : ready0, 1'b1);
        for (int k = 1; k <= fl; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (sel) begin dat1 = 8'($urandom); if (!hold) valid1 = 1'b0; end
                else     begin dat0 = 8'($urandom); if (!hold) valid0 = 1'b0; end
            end
            idx = (k - 1) / div;
            exp_bit = (P == 1 && idx == 9) ? exp_par : frame_bit(d, idx);
            check("cmd_bit", sel ? cmd1 : cmd0, exp_bit);
            check("sent_low_in_frame", sel ? sent1 : sent0, 1'b0);
            if (k == 1 || k == fl) begin
                check("ready_low_in_frame", sel ? ready1 : ready0, 1'b0);
                check("busy_in_frame", sel ? busy1 : busy0, 1'b1);
            end
        end
        @(negedge clk);
        if (sel) exp_cnt1 = exp_cnt1 + 16'd1;
        else     exp_cnt0 = exp_cnt0 + 16'd1;
        check("sent_pulse", sel ? sent1 : sent0, 1'b1);
        check("ready_at_done", sel ? ready1 : ready0, 1'b1);
        check("busy_at_done", sel ? busy1 : busy0, 1'b0);
        check("cmd_at_done", sel ? cmd1 : cmd0, 1'b0);
        check("sent_cnt", sel ? cnt1 : cnt0, sel ? exp_cnt1 : exp_cnt0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_cmd0", cmd0, 1'b0);
            check("idle_sent0", sent0, 1'b0);
            check("idle_ready0", ready0, 1'b1);
        end
    endtask

    typedef struct {
        logic [7:0] dat;
        logic       par;
        bit         hold;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{dat: 8'hA5, par: 1'b1, hold: 1'b0};
        tbl[1] = '{dat: 8'hFF, par: 1'b1, hold: 1'b0};
        tbl[2] = '{dat: 8'hFE, par: 1'b0, hold: 1'b0};
        tbl[3] = '{dat: 8'h01, par: 1'b0, hold: 1'b1};
        tbl[4] = '{dat: 8'h80, par: 1'b0, hold: 1'b0};
        tbl[5] = '{dat: 8'h3C, par: 1'b1, hold: 1'b0};

        // Reset values
        #1;
        check("rst_cmd", cmd0, 1'b0);
        check("rst_ready", ready0, 1'b1);
        check("rst_busy", busy0, 1'b0);
        check("rst_sent", sent0, 1'b0);
        check("rst_cnt", cnt0, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);

        // Table vectors; 8'h01 held into 8'h80 gives the back-to-back case
        for (int i = 0; i < 6; i++) begin
            send(1'b0, tbl[i].dat, tbl[i].par, tbl[i].hold);
        end
        idle_cycles(2);

        // Reset mid-frame at cycle 20
        dat0 = 8'hA5; valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd", cmd0, 1'b0);
        check("midrst_ready", ready0, 1'b1);
        check("midrst_cnt", cnt0, 16'h0);
        check("midrst_sent", sent0, 1'b0);
        exp_cnt0 = '0;
        exp_cnt1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(60);
        send(1'b0, 8'h5A, 1'b1, 1'b0);

        // CLK_DIV=1 instance, then counter wrap
        @(negedge clk);
        send(1'b1, 8'h3C, 1'b1, 1'b0);
        @(negedge clk);
        force dut1.sent_cnt = 16'hFFFF;
        #1;
        release dut1.sent_cnt;
        exp_cnt1 = 16'hFFFF;
        check("preload_cnt", cnt1, exp_cnt1);
        @(negedge clk);
        send(1'b1, 8'h3C, 1'b1, 1'b0);

        // Random frames against the model
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            bit sel;
            d = 8'($urandom);
            sel = 1'($urandom);
            send(sel, d, frame_bit(d, 9), 1'($urandom));
            valid0 = 1'b0;
            valid1 = 1'b0;
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 5));
            else @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 2_000_000);
        $fatal(1);
    end

endmodule
